// File: rtl/fetcher_if.sv
// Handshake/bus bundle of the instruction fetch unit: PC-block request, memory
// controller read port, and the PC-block/decoder result groups.
interface fetcher_if;
  logic        in_rdy;
  logic        in_flush_enable;
  logic        in_pc_enable;
  logic [31:0] in_pc;
  logic        in_pc_predict;
  logic        out_pc_last_enable;
  logic [31:0] out_pc_last_inst;
  logic        out_mem_req;
  logic [31:0] out_mem_addr;
  logic        in_mem_done;
  logic [31:0] in_mem_data;
  logic        out_decode_enable;
  logic [31:0] out_decode_inst;
  logic [31:0] out_decode_pc;
  logic        out_decode_predict;

  // master is the fetcher itself; slave is the surrounding pipeline/memory side
  modport master (
    input  in_rdy, in_flush_enable, in_pc_enable, in_pc, in_pc_predict,
           in_mem_done, in_mem_data,
    output out_pc_last_enable, out_pc_last_inst, out_mem_req, out_mem_addr,
           out_decode_enable, out_decode_inst, out_decode_pc, out_decode_predict
  );

  modport slave (
    output in_rdy, in_flush_enable, in_pc_enable, in_pc, in_pc_predict,
           in_mem_done, in_mem_data,
    input  out_pc_last_enable, out_pc_last_inst, out_mem_req, out_mem_addr,
           out_decode_enable, out_decode_inst, out_decode_pc, out_decode_predict
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch unit: one request at a time through a direct-mapped,
// one-word-per-line instruction cache, refilling from memory on a miss.
module fetcher #(
  parameter int ICACHE_INDEX_W = 8
) (
  input  logic      in_clk,
  input  logic      in_rst,
  fetcher_if.master bus
);

  localparam int LINES = 1 << ICACHE_INDEX_W;
  localparam int TAG_W = 30 - ICACHE_INDEX_W;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                    r_state;
  logic [LINES-1:0]          r_valid;
  logic [TAG_W-1:0]          r_tag  [LINES];
  logic [31:0]               r_data [LINES];
  logic [31:0]               r_pc;
  logic                      r_predict;
  logic                      r_pc_last_enable;
  logic [31:0]               r_pc_last_inst;
  logic                      r_mem_req;
  logic [31:0]               r_mem_addr;
  logic                      r_decode_enable;
  logic [31:0]               r_decode_inst;
  logic [31:0]               r_decode_pc;
  logic                      r_decode_predict;

  logic [ICACHE_INDEX_W-1:0] w_req_idx;
  logic [TAG_W-1:0]          w_req_tag;
  logic [ICACHE_INDEX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0]          w_fill_tag;
  logic                      w_hit;
  logic                      w_fill;

  assign w_req_idx  = bus.in_pc[ICACHE_INDEX_W+1:2];
  assign w_req_tag  = bus.in_pc[31:ICACHE_INDEX_W+2];
  assign w_fill_idx = r_pc[ICACHE_INDEX_W+1:2];
  assign w_fill_tag = r_pc[31:ICACHE_INDEX_W+2];
  assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  // A refill is written even when a flush arrives in the same cycle
  assign w_fill     = bus.in_rdy && (r_state == WAIT_MEM) && bus.in_mem_done;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state          <= IDLE;
      r_valid          <= '0;
      r_pc             <= '0;
      r_predict        <= 1'b0;
      r_pc_last_enable <= 1'b0;
      r_pc_last_inst   <= '0;
      r_mem_req        <= 1'b0;
      r_mem_addr       <= '0;
      r_decode_enable  <= 1'b0;
      r_decode_inst    <= '0;
      r_decode_pc      <= '0;
      r_decode_predict <= 1'b0;
    end else if (bus.in_rdy) begin
      r_pc_last_enable <= 1'b0;
      r_decode_enable  <= 1'b0;
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
      if (bus.in_flush_enable) begin
        r_state   <= IDLE;
        r_mem_req <= 1'b0;
      end else if (r_state == IDLE) begin
        if (bus.in_pc_enable) begin
          r_pc      <= bus.in_pc;
          r_predict <= bus.in_pc_predict;
          if (w_hit) begin
            r_pc_last_enable <= 1'b1;
            r_pc_last_inst   <= r_data[w_req_idx];
            r_decode_enable  <= 1'b1;
            r_decode_inst    <= r_data[w_req_idx];
            r_decode_pc      <= bus.in_pc;
            r_decode_predict <= bus.in_pc_predict;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= bus.in_pc;
            r_state    <= WAIT_MEM;
          end
        end
      end else begin
        if (bus.in_mem_done) begin
          r_mem_req        <= 1'b0;
          r_pc_last_enable <= 1'b1;
          r_pc_last_inst   <= bus.in_mem_data;
          r_decode_enable  <= 1'b1;
          r_decode_inst    <= bus.in_mem_data;
          r_decode_pc      <= r_pc;
          r_decode_predict <= r_predict;
          r_state          <= IDLE;
        end
      end
    end
  end

  // Tag/data arrays need no reset; the valid bits alone qualify them
  always_ff @(posedge in_clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.in_mem_data;
    end
  end

  assign bus.out_pc_last_enable = r_pc_last_enable;
  assign bus.out_pc_last_inst   = r_pc_last_inst;
  assign bus.out_mem_req        = r_mem_req;
  assign bus.out_mem_addr       = r_mem_addr;
  assign bus.out_decode_enable  = r_decode_enable;
  assign bus.out_decode_inst    = r_decode_inst;
  assign bus.out_decode_pc      = r_decode_pc;
  assign bus.out_decode_predict = r_decode_predict;

endmodule

// File: tb/tb_fetcher.sv
// Directed self-checking bench for the fetcher: cold/hit/conflict misses,
// flushes, in_rdy stalls and reset in the middle of a miss.
module tb_fetcher;

  logic in_clk;
  logic in_rst;
  int   testsRun;
  int   testsFailed;

  fetcher_if bus ();

  fetcher #(.ICACHE_INDEX_W(8)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic predict);
    bus.in_pc         = pc;
    bus.in_pc_predict = predict;
    bus.in_pc_enable  = 1'b1;
    tick();
    bus.in_pc_enable  = 1'b0;
  endtask

  task automatic memDone(input logic [31:0] data);
    bus.in_mem_data = data;
    bus.in_mem_done = 1'b1;
    tick();
    bus.in_mem_done = 1'b0;
  endtask

  task automatic checkPulse(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc, input logic predict);
    checkOutput({tag, "_pcEn"},   {31'd0, bus.out_pc_last_enable}, 32'd1);
    checkOutput({tag, "_decEn"},  {31'd0, bus.out_decode_enable},  32'd1);
    checkOutput({tag, "_pcInst"}, bus.out_pc_last_inst,            inst);
    checkOutput({tag, "_decInst"}, bus.out_decode_inst,            inst);
    checkOutput({tag, "_decPc"},  bus.out_decode_pc,               pc);
    checkOutput({tag, "_pred"},   {31'd0, bus.out_decode_predict}, {31'd0, predict});
    checkOutput({tag, "_req"},    {31'd0, bus.out_mem_req},        32'd0);
  endtask

  task automatic checkQuiet(input string tag, input logic memReq);
    checkOutput({tag, "_pcEn"},  {31'd0, bus.out_pc_last_enable}, 32'd0);
    checkOutput({tag, "_decEn"}, {31'd0, bus.out_decode_enable},  32'd0);
    checkOutput({tag, "_req"},   {31'd0, bus.out_mem_req},        {31'd0, memReq});
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    in_rst              = 1'b1;
    bus.in_rdy          = 1'b1;
    bus.in_flush_enable = 1'b0;
    bus.in_pc_enable    = 1'b0;
    bus.in_pc           = '0;
    bus.in_pc_predict   = 1'b0;
    bus.in_mem_done     = 1'b0;
    bus.in_mem_data     = '0;

    #2;
    checkQuiet("reset", 1'b0);
    checkOutput("reset_addr", bus.out_mem_addr, 32'h0);
    checkOutput("reset_inst", bus.out_decode_inst, 32'h0);
    checkOutput("reset_pc", bus.out_decode_pc, 32'h0);
    checkOutput("reset_pred", {31'd0, bus.out_decode_predict}, 32'd0);
    @(negedge in_clk);
    in_rst = 1'b0;
    tick();

    // Cold miss, memory answers after 4 cycles
    applyStimulus(32'h0, 1'b0);
    checkQuiet("cold_req", 1'b1);
    checkOutput("cold_addr", bus.out_mem_addr, 32'h0);
    repeat (3) tick();
    checkQuiet("cold_wait", 1'b1);
    memDone(32'h00500093);
    checkPulse("cold", 32'h00500093, 32'h0, 1'b0);
    tick();
    checkQuiet("cold_after", 1'b0);
    checkOutput("cold_hold", bus.out_decode_inst, 32'h00500093);

    applyStimulus(32'h0, 1'b0);
    checkPulse("hit0", 32'h00500093, 32'h0, 1'b0);
    tick();
    checkQuiet("hit0_after", 1'b0);

    // Conflict miss on index 4
    applyStimulus(32'h10, 1'b0);
    checkQuiet("c10_req", 1'b1);
    memDone(32'h11111111);
    checkPulse("c10", 32'h11111111, 32'h10, 1'b0);
    applyStimulus(32'h410, 1'b1);
    checkQuiet("c410_req", 1'b1);
    checkOutput("c410_addr", bus.out_mem_addr, 32'h410);
    memDone(32'h22222222);
    checkPulse("c410", 32'h22222222, 32'h410, 1'b1);
    applyStimulus(32'h10, 1'b0);
    checkQuiet("c10b_req", 1'b1);
    checkOutput("c10b_addr", bus.out_mem_addr, 32'h10);
    memDone(32'h11111111);
    checkPulse("c10b", 32'h11111111, 32'h10, 1'b0);

    // Flush two cycles into a miss, then a late done in IDLE
    applyStimulus(32'h20, 1'b0);
    checkQuiet("fl_req", 1'b1);
    tick();
    bus.in_flush_enable = 1'b1;
    tick();
    bus.in_flush_enable = 1'b0;
    checkQuiet("fl_cut", 1'b0);
    memDone(32'h99999999);
    checkQuiet("fl_late", 1'b0);
    applyStimulus(32'h20, 1'b0);
    checkQuiet("fl_nofill", 1'b1);
    memDone(32'h20202020);
    checkPulse("fl20", 32'h20202020, 32'h20, 1'b0);
    applyStimulus(32'h80, 1'b0);
    checkQuiet("f80_req", 1'b1);
    checkOutput("f80_addr", bus.out_mem_addr, 32'h80);
    memDone(32'h80808080);
    checkPulse("f80", 32'h80808080, 32'h80, 1'b0);

    // Flush together with mem done still fills the line
    applyStimulus(32'h30, 1'b0);
    checkQuiet("fd_req", 1'b1);
    tick();
    bus.in_flush_enable = 1'b1;
    memDone(32'hDEADBEEF);
    bus.in_flush_enable = 1'b0;
    checkQuiet("fd_cut", 1'b0);
    applyStimulus(32'h30, 1'b0);
    checkPulse("fd_hit", 32'hDEADBEEF, 32'h30, 1'b0);

    // Request dropped when flush arrives in the same cycle
    bus.in_flush_enable = 1'b1;
    applyStimulus(32'h100, 1'b0);
    bus.in_flush_enable = 1'b0;
    checkQuiet("fdrop", 1'b0);

    // in_rdy low for 3 cycles while mem done is presented
    applyStimulus(32'h44, 1'b1);
    checkQuiet("rdy_req", 1'b1);
    tick();
    bus.in_rdy      = 1'b0;
    bus.in_mem_data = 32'hCAFEF00D;
    bus.in_mem_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkQuiet("rdy_hold", 1'b1);
      checkOutput("rdy_pcHold", bus.out_decode_pc, 32'h30);
    end
    bus.in_rdy = 1'b1;
    tick();
    bus.in_mem_done = 1'b0;
    checkPulse("rdy", 32'hCAFEF00D, 32'h44, 1'b1);

    // Reset during a miss clears the request and the cache
    applyStimulus(32'h200, 1'b0);
    checkQuiet("rst_req", 1'b1);
    in_rst = 1'b1;
    #1;
    checkQuiet("rst_async", 1'b0);
    @(negedge in_clk);
    in_rst = 1'b0;
    tick();
    applyStimulus(32'h0, 1'b0);
    checkQuiet("rst_miss", 1'b1);
    checkOutput("rst_addr", bus.out_mem_addr, 32'h0);
    memDone(32'h00500093);
    checkPulse("rst_fill", 32'h00500093, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch unit sitting between the PC/branch-predictor block and the decoder. It accepts one fetch request at a time from the PC block and looks it up in a direct-mapped instruction cache. On a miss it reads the word through the memory controller. It returns the instruction both to the PC block, which uses it for next-PC prediction, and to the decoder, along with the PC and the prediction bit.

## Interface
Parameters:
- `ICACHE_INDEX_W`, default 8: index width; the cache holds 2^8 = 256 one-word lines.

Ports:
- `in_clk` in 1: clock.
- `in_rst` in 1: reset, asynchronous, active-high.
- `in_rdy` in 1: global ready. When low, every register (including outputs) holds.
- `in_flush_enable` in 1: mispredict flush from commit; aborts the in-flight fetch.
- `in_pc_enable` in 1: fetch request from the PC block.
- `in_pc` in 32: address to fetch; word-aligned.
- `in_pc_predict` in 1: taken/not-taken prediction attached to `in_pc`.
- `out_pc_last_enable` out 1: one-cycle pulse; instruction returned to the PC block.
- `out_pc_last_inst` out 32: instruction for the PC block.
- `out_mem_req` out 1: memory read request; level, held until done or cancelled.
- `out_mem_addr` out 32: read address.
- `in_mem_done` in 1: one-cycle pulse; read data valid.
- `in_mem_data` in 32: read data, little-endian word.
- `out_decode_enable` out 1: one-cycle pulse; instruction to the decoder.
- `out_decode_inst` out 32: instruction.
- `out_decode_pc` out 32: its PC.
- `out_decode_predict` out 1: its prediction bit.

## Operation
- Cache line fields: valid bit, tag = `pc[31:ICACHE_INDEX_W+2]`, data word.
  - Index = `pc[ICACHE_INDEX_W+1:2]`.
  - Bits `pc[1:0]` are ignored.
- State machine with two states, IDLE and WAIT_MEM.
- IDLE, `in_pc_enable=1`, no flush: latch `in_pc` and `in_pc_predict`, then do the lookup in the same cycle.
  - Hit: pulse both outputs next cycle with the cache data; stay in IDLE.
  - Miss: next cycle `out_mem_req=1` and `out_mem_addr=in_pc`; go to WAIT_MEM.
- WAIT_MEM, `in_mem_done=1`:
  - Write line (valid=1, tag, `in_mem_data`).
  - Deassert `out_mem_req`.
  - Pulse both output groups next cycle with `in_mem_data`, the latched PC and the latched predict bit.
  - Return to IDLE.
- `in_pc_enable` during WAIT_MEM is a protocol violation; it is ignored.
- Flush (highest priority):
  - Drop any `in_pc_enable` in the same cycle.
  - Next cycle `out_mem_req=0`, and both output enables are 0 even if a result was due.
  - Go to IDLE.
  - If `in_mem_done` coincides with flush, the cache line is still written, but nothing is forwarded.
- The memory controller treats a deasserted `out_mem_req` as a cancel. A late `in_mem_done` seen in IDLE is ignored and does not write the cache.
- The cache is never flushed by `in_flush_enable` (no self-modifying code).
- Output data registers hold their last value when the enables are low.

## Timing
- Reset (async, all cleared immediately):
  - all valid bits 0;
  - state IDLE;
  - `out_pc_last_enable`, `out_decode_enable`, `out_mem_req` = 0;
  - all data/address outputs 0;
  - `out_decode_predict` 0.
- Hit latency: request sampled at edge t, output pulses visible after edge t+1, width exactly one cycle.
- Miss: `out_mem_req` rises after edge t+1. If `in_mem_done` is sampled at edge k, the output pulses appear after edge k+1 and `out_mem_req` falls after edge k+1.
- `out_pc_last_enable` and `out_decode_enable` are always asserted together, with identical instruction values.
- At most one request is outstanding at a time; the PC block waits for `out_pc_last_enable` before issuing the next one.
- With `in_rdy=0`: no state, cache or output change; `in_mem_done` and `in_pc_enable` are not sampled.

## Test plan
- Reset mid-miss: assert `in_rst` while in WAIT_MEM → `out_mem_req` drops immediately. A following request to the same PC misses again, because valid bits are cleared.
- Cold miss then hit:
  - Request `0x00000000` predict 0; mem returns `0x00500093` after 4 cycles → one pulse with inst `0x00500093`, pc `0x0`, predict 0.
  - Re-request `0x0` → pulse exactly 1 cycle later, no `out_mem_req`.
- Conflict miss: with `ICACHE_INDEX_W=8`, fetch `0x00000010` then `0x00000410` (same index, different tag) → the second fetch misses and issues `out_mem_req` with addr `0x410`. Re-fetching `0x10` then misses again.
- Flush during miss:
  - Request `0x20`, flush 2 cycles later → `out_mem_req` low next cycle, no output pulses.
  - A late `in_mem_done` is ignored; a new request to `0x80` proceeds normally.
- Flush coincident with `in_mem_done` for `0x30` (data `0xDEADBEEF`) → no pulses, but a later request to `0x30` hits and returns `0xDEADBEEF`.
- Predict bit and `in_rdy`: request `0x44` with predict 1 and hold `in_rdy=0` for 3 cycles around the mem done → the outputs are delayed exactly 3 cycles, and the pulse carries predict 1 and pc `0x44`.
